ysyx_20020207_icache: RTL and testbench

Direct-mapped instruction cache between the IFU fetch port and the core's read arbiter. It accepts single-word fetch requests from the IFU over an AXI-lite style read channel. Hits are answered from local storage. Misses issue one AXI4 INCR burst per line on the downstream read channel toward the arbiter and crossbar.

---
 rtl/ysyx_20020207_icache_pkg.sv | 18 +
 rtl/ysyx_20020207_icache_array.sv | 54 +++++
 rtl/ysyx_20020207_icache.sv | 180 ++++++++++++++++++
 tb/tb_ysyx_20020207_icache.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_20020207_icache_pkg.sv
// Shared types and constants for the instruction cache.
// FSM state encoding and AXI field constants.
package ysyx_20020207_icache_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    REFILL_AR,
    REFILL_R,
    RESP_ERR
  } state_t;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_WORD  = 3'b010;
  localparam logic [1:0] RESP_OKAY      = 2'b00;
  localparam logic [1:0] RESP_SLVERR    = 2'b10;

endpackage

// File: rtl/ysyx_20020207_icache_array.sv
// Tag, valid and data storage for the direct-mapped icache.
// Combinational read by index, per-word write, one-cycle clear.
module ysyx_20020207_icache_array #(
  parameter int LINE_NUM    = 16,
  parameter int BLOCK_WORDS = 4,
  parameter int TAG_W       = 24,
  parameter int IDX_W       = $clog2(LINE_NUM),
  parameter int OFF_W       = $clog2(BLOCK_WORDS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  input  logic [OFF_W-1:0] rd_off,
  output logic             rd_valid,
  output logic [TAG_W-1:0] rd_tag,
  output logic [31:0]      rd_word,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_en,
  input  logic [OFF_W-1:0] wr_off,
  input  logic [31:0]      wr_data,
  input  logic             tag_we,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic             inv_en,
  input  logic             clr
);

  logic [31:0]         data_q [LINE_NUM][BLOCK_WORDS];
  logic [TAG_W-1:0]    tag_q  [LINE_NUM];
  logic [LINE_NUM-1:0] valid_q;

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_word  = data_q[rd_idx][rd_off];

  // Data and tag storage need no reset; valid bits gate them.
  always_ff @(posedge clk) begin
    if (wr_en)  data_q[wr_idx][wr_off] <= wr_data;
    if (tag_we) tag_q[wr_idx] <= wr_tag;
  end

  // Valid bits: global clear beats line invalidate beats line set.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q <= '0;
    end else if (clr) begin
      valid_q <= '0;
    end else if (inv_en) begin
      valid_q[wr_idx] <= 1'b0;
    end else if (tag_we) begin
      valid_q[wr_idx] <= 1'b1;
    end
  end

endmodule

// File: rtl/ysyx_20020207_icache.sv
// Direct-mapped icache: IFU AXI-lite fetch port, AXI4 burst refill.
// Define ICACHE_PERF_EN to add perf_hit / perf_miss counters.
module ysyx_20020207_icache
  import ysyx_20020207_icache_pkg::*;
#(
  parameter int LINE_NUM    = 16,
  parameter int BLOCK_WORDS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        fence_i,
  input  logic        ifu_arvalid,
  output logic        ifu_arready,
  input  logic [31:0] ifu_araddr,
  output logic        ifu_rvalid,
  input  logic        ifu_rready,
  output logic [31:0] ifu_rdata,
  output logic [1:0]  ifu_rresp,
  output logic        mem_arvalid,
  input  logic        mem_arready,
  output logic [31:0] mem_araddr,
  output logic [7:0]  mem_arlen,
  output logic [2:0]  mem_arsize,
  output logic [1:0]  mem_arburst,
  input  logic        mem_rvalid,
  output logic        mem_rready,
  input  logic [31:0] mem_rdata,
  input  logic [1:0]  mem_rresp,
  input  logic        mem_rlast
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0] perf_hit,
  output logic [31:0] perf_miss
`endif
);

  localparam int OFF_W = $clog2(BLOCK_WORDS);
  localparam int IDX_W = $clog2(LINE_NUM);
  localparam int TAG_W = 32 - 2 - OFF_W - IDX_W;
  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(BLOCK_WORDS - 1);

  state_t           state;
  logic [31:2]      addr_q;
  logic [OFF_W-1:0] beat_cnt;
  logic             err_q;
  logic             pend_q;
  logic             first_q;

  logic [IDX_W-1:0] idx;
  logic [OFF_W-1:0] off;
  logic [TAG_W-1:0] tag;
  logic             rd_valid;
  logic [TAG_W-1:0] rd_tag;
  logic [31:0]      rd_word;
  logic             hit;
  logic             beat_en;
  logic             last_good;
  logic             go_idle;
  logic             clr;
  logic             unused_ok;

  assign unused_ok = &{1'b0, ifu_araddr[1:0]};

  assign idx = addr_q[OFF_W+2 +: IDX_W];
  assign off = addr_q[2 +: OFF_W];
  assign tag = addr_q[31 -: TAG_W];
  assign hit = rd_valid && (rd_tag == tag);

  assign beat_en   = (state == REFILL_R) && mem_rvalid;
  assign last_good = beat_en && mem_rlast && !err_q
                  && (mem_rresp == RESP_OKAY)
                  && (beat_cnt == LAST_BEAT);
  assign go_idle = ifu_rready
                && (((state == LOOKUP) && hit)
                 || (state == RESP_ERR));
  assign clr = ((state == IDLE) && fence_i)
            || (go_idle && (pend_q || fence_i));

  ysyx_20020207_icache_array #(
    .LINE_NUM   (LINE_NUM),
    .BLOCK_WORDS(BLOCK_WORDS),
    .TAG_W      (TAG_W)
  ) u_array (
    .clk     (clk),
    .rst     (rst),
    .rd_idx  (idx),
    .rd_off  (off),
    .rd_valid(rd_valid),
    .rd_tag  (rd_tag),
    .rd_word (rd_word),
    .wr_idx  (idx),
    .wr_en   (beat_en),
    .wr_off  (beat_cnt),
    .wr_data (mem_rdata),
    .tag_we  (last_good),
    .wr_tag  (tag),
    .inv_en  ((state == LOOKUP) && !hit),
    .clr     (clr)
  );

  assign ifu_arready = (state == IDLE);
  assign ifu_rvalid  = ((state == LOOKUP) && hit)
                    || (state == RESP_ERR);
  assign ifu_rdata   = ((state == LOOKUP) && hit) ? rd_word : '0;
  assign ifu_rresp   = (state == RESP_ERR) ? RESP_SLVERR : RESP_OKAY;
  assign mem_arvalid = (state == REFILL_AR);
  assign mem_rready  = (state == REFILL_R);
  assign mem_araddr  = {addr_q[31:OFF_W+2], {(OFF_W+2){1'b0}}};
  assign mem_arlen   = 8'(BLOCK_WORDS - 1);
  assign mem_arsize  = AXI_SIZE_WORD;
  assign mem_arburst = AXI_BURST_INCR;

  // Request sequencing: lookup, burst refill, response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      addr_q   <= '0;
      beat_cnt <= '0;
      err_q    <= 1'b0;
      pend_q   <= 1'b0;
      first_q  <= 1'b0;
    end else begin
      if (go_idle)
        pend_q <= 1'b0;
      else if (fence_i && (state != IDLE))
        pend_q <= 1'b1;
      unique case (state)
        IDLE: begin
          if (ifu_arvalid) begin
            addr_q  <= ifu_araddr[31:2];
            first_q <= 1'b1;
            state   <= LOOKUP;
          end
        end
        LOOKUP: begin
          first_q <= 1'b0;
          if (!hit) begin
            beat_cnt <= '0;
            err_q    <= 1'b0;
            state    <= REFILL_AR;
          end else if (ifu_rready) begin
            state <= IDLE;
          end
        end
        REFILL_AR: begin
          if (mem_arready) state <= REFILL_R;
        end
        REFILL_R: begin
          if (mem_rvalid) begin
            beat_cnt <= beat_cnt + 1'b1;
            err_q    <= err_q | (mem_rresp != RESP_OKAY);
            if (mem_rlast) begin
              beat_cnt <= '0;
              err_q    <= 1'b0;
              state    <= last_good ? LOOKUP : RESP_ERR;
            end
          end
        end
        RESP_ERR: begin
          if (ifu_rready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef ICACHE_PERF_EN
  // One count per request, on its first lookup only.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_hit  <= '0;
      perf_miss <= '0;
    end else if ((state == LOOKUP) && first_q) begin
      if (hit) perf_hit  <= perf_hit + 32'd1;
      else     perf_miss <= perf_miss + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ysyx_20020207_icache.sv
// Scoreboard bench for ysyx_20020207_icache with an AXI burst memory.
// Inputs change on negedge; outputs sampled at negedge + 2.
module tb_ysyx_20020207_icache;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        fence_i = 1'b0;
  logic        ifu_arvalid = 1'b0;
  logic        ifu_arready;
  logic [31:0] ifu_araddr = '0;
  logic        ifu_rvalid;
  logic        ifu_rready = 1'b1;
  logic [31:0] ifu_rdata;
  logic [1:0]  ifu_rresp;
  logic        mem_arvalid;
  logic        mem_arready;
  logic [31:0] mem_araddr;
  logic [7:0]  mem_arlen;
  logic [2:0]  mem_arsize;
  logic [1:0]  mem_arburst;
  logic        mem_rvalid;
  logic        mem_rready;
  logic [31:0] mem_rdata;
  logic [1:0]  mem_rresp;
  logic        mem_rlast;
`ifdef ICACHE_PERF_EN
  logic [31:0] perf_hit;
  logic [31:0] perf_miss;
`endif

  ysyx_20020207_icache dut (
    .clk        (clk),
    .rst        (rst),
    .fence_i    (fence_i),
    .ifu_arvalid(ifu_arvalid),
    .ifu_arready(ifu_arready),
    .ifu_araddr (ifu_araddr),
    .ifu_rvalid (ifu_rvalid),
    .ifu_rready (ifu_rready),
    .ifu_rdata  (ifu_rdata),
    .ifu_rresp  (ifu_rresp),
    .mem_arvalid(mem_arvalid),
    .mem_arready(mem_arready),
    .mem_araddr (mem_araddr),
    .mem_arlen  (mem_arlen),
    .mem_arsize (mem_arsize),
    .mem_arburst(mem_arburst),
    .mem_rvalid (mem_rvalid),
    .mem_rready (mem_rready),
    .mem_rdata  (mem_rdata),
    .mem_rresp  (mem_rresp),
    .mem_rlast  (mem_rlast)
`ifdef ICACHE_PERF_EN
    ,
    .perf_hit   (perf_hit),
    .perf_miss  (perf_miss)
`endif
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;
  int ar_cnt = 0;
  int ar_delay = 0;
  int n_beats = 4;
  int err_beat = -1;
  int n_hit = 0;
  int n_miss = 0;
  logic [31:0] exp_line = '0;
  logic [31:0] sb_data [$];
  logic [1:0]  sb_resp [$];

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] memf(input logic [31:0] a);
    return ((a - 32'h3000_0000) >> 2) + 32'hA0;
  endfunction

  // Downstream memory: AR with ar_delay wait, then n_beats beats.
  initial begin : mem_model
    logic [31:0] line;
    int g;
    mem_arready = 1'b0;
    mem_rvalid  = 1'b0;
    mem_rdata   = '0;
    mem_rresp   = 2'b00;
    mem_rlast   = 1'b0;
    forever begin
      @(negedge clk);
      if (rst && mem_arvalid) begin
        line = mem_araddr;
        chk("araddr", mem_araddr, exp_line);
        chk("arlen", 32'(mem_arlen), 32'd3);
        chk("arsize", 32'(mem_arsize), 32'd2);
        chk("arburst", 32'(mem_arburst), 32'd1);
        for (int i = 0; i < ar_delay; i++) begin
          @(negedge clk);
          chk("ar_hold", {31'd0, mem_arvalid}, 32'd1);
          chk("ar_addr_hold", mem_araddr, line);
        end
        mem_arready = 1'b1;
        @(negedge clk);
        mem_arready = 1'b0;
        ar_cnt++;
        for (int b = 0; b < n_beats; b++) begin
          mem_rvalid = 1'b1;
          mem_rdata  = memf(line + 32'(4 * b));
          mem_rresp  = (b == err_beat) ? 2'b10 : 2'b00;
          mem_rlast  = (b == n_beats - 1);
          g = 0;
          while (!mem_rready && g < 50) begin
            @(negedge clk);
            g++;
          end
          @(negedge clk);
        end
        mem_rvalid = 1'b0;
        mem_rlast  = 1'b0;
        mem_rresp  = 2'b00;
      end
    end
  end

  // Response side of the scoreboard.
  initial begin : monitor
    forever begin
      @(negedge clk);
      #2;
      if (rst && ifu_rvalid && ifu_rready) begin
        if (sb_data.size() == 0) begin
          chk("sb_underflow", 32'd1, 32'd0);
        end else begin
          chk("rdata", ifu_rdata, sb_data.pop_front());
          chk("rresp", 32'(ifu_rresp), 32'(sb_resp.pop_front()));
        end
      end
    end
  end

  task automatic fetch(input logic [31:0] a,
                       input logic [31:0] d,
                       input logic [1:0]  r,
                       input bit          miss,
                       input int          hold,
                       input bit          fen);
    int lat;
    int want;
    exp_line = {a[31:4], 4'h0};
    want = miss ? (ar_delay + 2 + n_beats) : 0;
    if (miss) n_miss++;
    else n_hit++;
    sb_data.push_back(d);
    sb_resp.push_back(r);
    @(negedge clk);
    ifu_arvalid = 1'b1;
    ifu_araddr  = a;
    ifu_rready  = (hold == 0);
    fence_i     = fen;
    chk("arready", {31'd0, ifu_arready}, 32'd1);
    @(negedge clk);
    ifu_arvalid = 1'b0;
    fence_i     = 1'b0;
    lat = 0;
    while (!ifu_rvalid && lat < 300) begin
      @(negedge clk);
      lat++;
    end
    chk("latency", 32'(lat), 32'(want));
    for (int i = 0; i < hold; i++) begin
      #2;
      chk("hold_valid", {31'd0, ifu_rvalid}, 32'd1);
      chk("hold_data", ifu_rdata, d);
      @(negedge clk);
    end
    ifu_rready = 1'b1;
    @(negedge clk);
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin : main
    repeat (3) @(negedge clk);
    #2;
    chk("rst_arready", {31'd0, ifu_arready}, 32'd1);
    chk("rst_rvalid", {31'd0, ifu_rvalid}, 32'd0);
    chk("rst_arvalid", {31'd0, mem_arvalid}, 32'd0);
    chk("rst_rready", {31'd0, mem_rready}, 32'd0);
    chk("rst_rdata", ifu_rdata, 32'd0);
    chk("rst_rresp", 32'(ifu_rresp), 32'd0);
    chk("rst_araddr", mem_araddr, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    ar_delay = 1;
    fetch(32'h3000_0008, 32'hA2, 2'b00, 1, 0, 0);
    fetch(32'h3000_000C, 32'hA3, 2'b00, 0, 0, 0);
    chk("no_burst_on_hit", 32'(ar_cnt), 32'd1);

    ar_delay = 0;
    fetch(32'h3000_0000, 32'hA0, 2'b00, 1, 0, 1);
    ar_delay = 2;
    fetch(32'h3000_0100, memf(32'h3000_0100), 2'b00, 1, 0, 0);
    fetch(32'h3000_0004, 32'hA1, 2'b00, 1, 0, 0);
    chk("conflict_bursts", 32'(ar_cnt), 32'd4);

    ar_delay = 0;
    err_beat = 2;
    fetch(32'h3000_0204, 32'h0, 2'b10, 1, 0, 0);
    err_beat = -1;
    fetch(32'h3000_0204, memf(32'h3000_0204), 2'b00, 1, 0, 0);

    n_beats = 2;
    fetch(32'h3000_0040, 32'h0, 2'b10, 1, 0, 0);
    n_beats = 4;
    fetch(32'h3000_0048, memf(32'h3000_0048), 2'b00, 1, 0, 0);
    chk("error_bursts", 32'(ar_cnt), 32'd8);

    ar_delay = 1;
    fork
      fetch(32'h3000_0050, memf(32'h3000_0050), 2'b00, 1, 0, 0);
      begin : fence_pulse
        int g;
        g = 0;
        while (!mem_rready && g < 100) begin
          @(negedge clk);
          g++;
        end
        fence_i = 1'b1;
        @(negedge clk);
        fence_i = 1'b0;
      end
    join
    fetch(32'h3000_0054, memf(32'h3000_0054), 2'b00, 1, 0, 0);
    chk("fence_bursts", 32'(ar_cnt), 32'd10);

    fetch(32'h3000_0058, memf(32'h3000_0058), 2'b00, 0, 5, 0);
    for (int i = 0; i < 4; i++) begin
      logic [31:0] a;
      a = 32'h3000_0050 + 32'(4 * i);
      fetch(a, memf(a), 2'b00, 0, int'($urandom_range(0, 3)), 0);
    end
    chk("final_bursts", 32'(ar_cnt), 32'd10);

    repeat (3) @(negedge clk);
    chk("sb_drain", 32'(sb_data.size()), 32'd0);
`ifdef ICACHE_PERF_EN
    chk("perf_hit", perf_hit, 32'(n_hit));
    chk("perf_miss", perf_miss, 32'(n_miss));
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
